ascii_num_sep_ctrl: RTL and testbench

Sequencing controller for the ASCII number-separation path. It clears the character validator, waits for a full validated payload, screens it for invalid or empty content, launches the downstream number parser, and reports a single result or error per command. It sits between the command/top-level FSM and the validator/parser pair, and is their only source of `clear` and `start`.

---
 rtl/ascii_num_sep_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ascii_num_sep_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_num_sep_ctrl.sv
// ---------------------------------------------------------------------------
// ascii_num_sep_ctrl
//
// Sequencing controller for the ASCII number-separation path. It clears the
// character validator, waits for a complete validated payload, screens it
// for invalid or empty/oversize content, launches the number parser, and
// reports exactly one result or error per command.
//
// Parameters
//   TIMEOUT_CYCLES : idle-gap limit in RECEIVE and PARSE before a timeout
//   MAX_PAYLOAD    : largest legal val_length
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   start            : one-cycle command, honoured only in IDLE
//   payload_seen     : validator accepted a byte this cycle
//   val_done         : validator finished the payload (level)
//   val_invalid      : validator saw an illegal character
//   val_length[15:0] : validator buffer length, meaningful with val_done
//   val_clear        : one-cycle clear pulse to the validator
//   parse_start      : one-cycle start pulse to the parser
//   parse_done       : parser finished
//   parse_error      : parser found a malformed number (with parse_done)
//   parse_count[7:0] : number of values produced (with parse_done)
//   busy             : high whenever not IDLE
//   result_valid     : result/error available, held until result_ack
//   result_ack       : consumer accepts the result
//   err              : result is an error
//   err_code[1:0]    : 0 none, 1 invalid/parse error, 2 empty/oversize,
//                      3 timeout
//   num_count[7:0]   : parse_count on success, else 0
// ---------------------------------------------------------------------------
module ascii_num_sep_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned MAX_PAYLOAD    = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        payload_seen,
  input  logic        val_done,
  input  logic        val_invalid,
  input  logic [15:0] val_length,
  output logic        val_clear,
  output logic        parse_start,
  input  logic        parse_done,
  input  logic        parse_error,
  input  logic [7:0]  parse_count,
  output logic        busy,
  output logic        result_valid,
  input  logic        result_ack,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  num_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RECEIVE,
    ST_CHECK,
    ST_PARSE,
    ST_REPORT
  } state_t;

  localparam logic [1:0] CODE_OK      = 2'd0;
  localparam logic [1:0] CODE_INVALID = 2'd1;
  localparam logic [1:0] CODE_SIZE    = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  // Counter value at which the idle gap is exhausted.
  localparam logic [31:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [1:0]  check_code_reg, check_code_next;
  logic [1:0]  err_code_reg, err_code_next;
  logic [7:0]  num_count_reg, num_count_next;

  logic [31:0] cnt_inc;
  logic        timeout_hit;
  logic        size_bad;

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc     = (cnt_reg == '1) ? cnt_reg : cnt_reg + 32'd1;
  assign timeout_hit = (cnt_reg >= TIMEOUT_LAST);
  assign size_bad    = (val_length == 16'd0) || (32'(val_length) > MAX_PAYLOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      check_code_reg <= CODE_OK;
      err_code_reg   <= CODE_OK;
      num_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      check_code_reg <= check_code_next;
      err_code_reg   <= err_code_next;
      num_count_reg  <= num_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    check_code_next = check_code_reg;
    err_code_next   = err_code_reg;
    num_count_next  = num_count_reg;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (start) state_next = ST_CLEAR;
      end

      ST_CLEAR: begin
        cnt_next   = '0;
        state_next = ST_RECEIVE;
      end

      ST_RECEIVE: begin
        if (val_done) begin
          // The screening verdict is captured here (val_done is a level, so
          // the qualifiers are already stable) so that parse_start in CHECK
          // is decoded from registers, not from live inputs.
          state_next = ST_CHECK;
          if (val_invalid)   check_code_next = CODE_INVALID;
          else if (size_bad) check_code_next = CODE_SIZE;
          else               check_code_next = CODE_OK;
        end else if (payload_seen) begin
          cnt_next = '0;
        end else if (timeout_hit) begin
          state_next     = ST_REPORT;
          err_code_next  = CODE_TIMEOUT;
          num_count_next = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      ST_CHECK: begin
        cnt_next = '0;
        if (check_code_reg != CODE_OK) begin
          state_next     = ST_REPORT;
          err_code_next  = check_code_reg;
          num_count_next = '0;
        end else begin
          state_next = ST_PARSE;
        end
      end

      ST_PARSE: begin
        if (parse_done) begin
          state_next = ST_REPORT;
          if (parse_error) begin
            err_code_next  = CODE_INVALID;
            num_count_next = '0;
          end else begin
            err_code_next  = CODE_OK;
            num_count_next = parse_count;
          end
        end else if (timeout_hit) begin
          state_next     = ST_REPORT;
          err_code_next  = CODE_TIMEOUT;
          num_count_next = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      ST_REPORT: begin
        if (result_ack) begin
          state_next      = ST_IDLE;
          err_code_next   = CODE_OK;
          num_count_next  = '0;
          check_code_next = CODE_OK;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decode state and registered result fields only.
  assign val_clear    = (state_reg == ST_CLEAR);
  assign parse_start  = (state_reg == ST_CHECK) && (check_code_reg == CODE_OK);
  assign busy         = (state_reg != ST_IDLE);
  assign result_valid = (state_reg == ST_REPORT);
  assign err          = result_valid && (err_code_reg != CODE_OK);
  assign err_code     = err_code_reg;
  assign num_count    = num_count_reg;

endmodule

// File: tb/tb_ascii_num_sep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ascii_num_sep_ctrl
//
// Directed testbench for ascii_num_sep_ctrl with TIMEOUT_CYCLES=16. Inputs
// are driven 1 ns after each rising edge; outputs are read at that point.
// ---------------------------------------------------------------------------
module tb_ascii_num_sep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        payload_seen = 1'b0;
  logic        val_done = 1'b0;
  logic        val_invalid = 1'b0;
  logic [15:0] val_length = 16'd0;
  logic        val_clear;
  logic        parse_start;
  logic        parse_done = 1'b0;
  logic        parse_error = 1'b0;
  logic [7:0]  parse_count = 8'd0;
  logic        busy;
  logic        result_valid;
  logic        result_ack = 1'b0;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  num_count;

  int checks = 0;
  int errors = 0;
  int vc_cnt = 0;
  int ps_cnt = 0;

  ascii_num_sep_ctrl #(
    .TIMEOUT_CYCLES(16),
    .MAX_PAYLOAD(2048)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .payload_seen(payload_seen),
    .val_done(val_done),
    .val_invalid(val_invalid),
    .val_length(val_length),
    .val_clear(val_clear),
    .parse_start(parse_start),
    .parse_done(parse_done),
    .parse_error(parse_error),
    .parse_count(parse_count),
    .busy(busy),
    .result_valid(result_valid),
    .result_ack(result_ack),
    .err(err),
    .err_code(err_code),
    .num_count(num_count)
  );

  always #5 clk = ~clk;

  // Pulse counters (one count per cycle the strobe is high).
  always @(negedge clk) begin
    if (val_clear)   vc_cnt++;
    if (parse_start) ps_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start in IDLE -> CLEAR next cycle -> RECEIVE the cycle after.
  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (val_clear !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_clear: val_clear=%0b busy=%0b required 1 1", tag, val_clear, busy);
    end
    tick();
    checks++;
    if (val_clear !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear_once: val_clear=%0b required 0", tag, val_clear);
    end
  endtask

  // From RECEIVE, present a clean payload and step into PARSE.
  task automatic goto_parse(input string tag, input logic [15:0] len);
    val_done = 1'b1; val_invalid = 1'b0; val_length = len;
    tick();
    val_done = 1'b0;
    checks++;
    if (parse_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_parse_start: parse_start=%0b required 1", tag, parse_start);
    end
    tick();
    checks++;
    if (parse_start !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_in_parse: parse_start=%0b result_valid=%0b required 0 0", tag, parse_start, result_valid);
    end
  endtask

  task automatic check_result(input string tag, input logic [1:0] code, input logic [7:0] cnt);
    checks++;
    if (result_valid !== 1'b1 || err !== (code != 2'd0) || err_code !== code || num_count !== cnt) begin
      errors++;
      $display("FAIL %s_result: valid=%0b err=%0b code=%0d count=%0d required 1 %0b %0d %0d",
               tag, result_valid, err, err_code, num_count, (code != 2'd0), code, cnt);
    end
  endtask

  task automatic do_ack(input string tag);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || err !== 1'b0 || err_code !== 2'd0 || num_count !== 8'd0) begin
      errors++;
      $display("FAIL %s_ack_idle: busy=%0b valid=%0b err=%0b code=%0d count=%0d required all 0",
               tag, busy, result_valid, err, err_code, num_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, val_clear, parse_start, result_valid, err, err_code, num_count} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h required 0",
               {busy, val_clear, parse_start, result_valid, err, err_code, num_count});
    end
    rst = 1'b0;
    tick();
    // result_ack outside REPORT must not do anything.
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_ack: busy=%0b required 0", busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_happy();
    int ps0 = ps_cnt;
    do_start("happy");
    for (int i = 0; i < 6; i++) begin
      payload_seen = 1'b1; tick();
      payload_seen = 1'b0; tick();
    end
    goto_parse("happy", 16'd6);
    parse_done = 1'b1; parse_count = 8'd3;
    tick();
    parse_done = 1'b0; parse_count = 8'd0;
    check_result("happy", 2'd0, 8'd3);
    tick(); tick();
    check_result("happy_hold", 2'd0, 8'd3);
    checks++;
    if (ps_cnt - ps0 !== 1) begin
      errors++;
      $display("FAIL happy_pulses: parse_start cycles=%0d required 1", ps_cnt - ps0);
    end
    do_ack("happy");
    $display("test_happy done");
  endtask

  task automatic test_invalid();
    int ps0 = ps_cnt;
    do_start("invalid");
    val_done = 1'b1; val_invalid = 1'b1; val_length = 16'd3;
    tick();
    val_done = 1'b0; val_invalid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_result($sformatf("invalid_hold%0d", i), 2'd1, 8'd0);
      tick();
    end
    checks++;
    if (ps_cnt - ps0 !== 0) begin
      errors++;
      $display("FAIL invalid_no_parse: parse_start cycles=%0d required 0", ps_cnt - ps0);
    end
    do_ack("invalid");
    $display("test_invalid done");
  endtask

  task automatic test_size();
    int ps0 = ps_cnt;
    logic [15:0] lens [2];
    lens[0] = 16'd0;
    lens[1] = 16'd2049;
    for (int i = 0; i < 2; i++) begin
      do_start("size");
      val_done = 1'b1; val_invalid = 1'b0; val_length = lens[i];
      tick();
      val_done = 1'b0;
      tick();
      check_result($sformatf("size_len%0d", lens[i]), 2'd2, 8'd0);
      do_ack("size");
    end
    checks++;
    if (ps_cnt - ps0 !== 0) begin
      errors++;
      $display("FAIL size_no_parse: parse_start cycles=%0d required 0", ps_cnt - ps0);
    end
    // Largest legal length must be accepted.
    do_start("size_max");
    goto_parse("size_max", 16'd2048);
    parse_done = 1'b1; parse_count = 8'd200;
    tick();
    parse_done = 1'b0;
    check_result("size_max", 2'd0, 8'd200);
    do_ack("size_max");
    $display("test_size done");
  endtask

  task automatic test_timeout();
    bit early = 0;
    do_start("tmo");
    // RECEIVE entered at cycle 2; result must appear at cycle 18.
    for (int i = 0; i < 15; i++) begin
      if (result_valid) early = 1;
      tick();
    end
    checks++;
    if (early || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: result_valid rose before cycle 18, required 0");
    end
    tick();
    check_result("tmo_receive", 2'd3, 8'd0);
    do_ack("tmo");

    // Keep-alive bytes every 10 cycles hold off the timeout.
    do_start("keepalive");
    early = 0;
    for (int i = 1; i <= 50; i++) begin
      payload_seen = (i % 10 == 0);
      tick();
      if (result_valid) early = 1;
    end
    payload_seen = 1'b0;
    checks++;
    if (early || busy !== 1'b1) begin
      errors++;
      $display("FAIL keepalive_no_timeout: timed out=%0b busy=%0b required 0 1", early, busy);
    end
    goto_parse("keepalive", 16'd4);
    parse_done = 1'b1; parse_count = 8'd1;
    tick();
    parse_done = 1'b0;
    check_result("keepalive", 2'd0, 8'd1);
    do_ack("keepalive");

    // Parser silence times out after 16 cycles in PARSE.
    do_start("ptmo");
    goto_parse("ptmo", 16'd5);
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL ptmo_early: result_valid=%0b required 0", result_valid);
    end
    tick();
    check_result("ptmo", 2'd3, 8'd0);
    do_ack("ptmo");
    $display("test_timeout done");
  endtask

  task automatic test_parse_err_collision();
    do_start("perr");
    goto_parse("perr", 16'd8);
    parse_done = 1'b1; parse_error = 1'b1; parse_count = 8'd9;
    tick();
    parse_done = 1'b0; parse_error = 1'b0;
    check_result("perr", 2'd1, 8'd0);
    do_ack("perr");

    // parse_done lands on the last timeout cycle of PARSE: done wins.
    do_start("coll");
    goto_parse("coll", 16'd8);
    for (int i = 0; i < 15; i++) tick();
    parse_done = 1'b1; parse_count = 8'd7;
    tick();
    parse_done = 1'b0;
    check_result("coll", 2'd0, 8'd7);
    do_ack("coll");
    $display("test_parse_err_collision done");
  endtask

  task automatic test_robust();
    int vc0 = vc_cnt;
    do_start("busy_start");
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; tick();
      start = 1'b0; tick();
    end
    checks++;
    if (vc_cnt - vc0 !== 1) begin
      errors++;
      $display("FAIL busy_start_ignored: val_clear cycles=%0d required 1", vc_cnt - vc0);
    end
    goto_parse("busy_start", 16'd2);
    // Reset in PARSE aborts at once.
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, val_clear, parse_start, result_valid, err, err_code, num_count} !== 15'd0) begin
      errors++;
      $display("FAIL rst_in_parse: got %0h required 0",
               {busy, val_clear, parse_start, result_valid, err, err_code, num_count});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (val_clear !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_clear: val_clear=%0b busy=%0b required 0 0", val_clear, busy);
    end
    // Fresh run, then start right on the cycle after ack.
    do_start("after_rst");
    goto_parse("after_rst", 16'd1);
    parse_done = 1'b1; parse_count = 8'd1;
    tick();
    parse_done = 1'b0;
    check_result("after_rst", 2'd0, 8'd1);
    do_ack("after_rst");
    do_start("b2b");
    val_done = 1'b1; val_invalid = 1'b1; val_length = 16'd1;
    tick();
    val_done = 1'b0; val_invalid = 1'b0;
    tick();
    check_result("b2b", 2'd1, 8'd0);
    do_ack("b2b");
    $display("test_robust done");
  endtask

  initial begin
    test_reset();
    test_happy();
    test_invalid();
    test_size();
    test_timeout();
    test_parse_err_collision();
    test_robust();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
